// File: rtl/regfile_seq.sv
// regfile_seq: buffers writebacks in a 2-entry FIFO and sequences exclusive read/write strobes to the register file
module regfile_seq #(
    parameter int WB_DEPTH = 2
) (
    input  logic        APB_PCLK,
    input  logic        reset,
    input  logic        rd_req_valid,
    output logic        rd_req_ready,
    input  logic [4:0]  rd_ra0,
    input  logic [4:0]  rd_ra1,
    output logic        rd_rsp_valid,
    output logic [31:0] rd_rs0,
    output logic [31:0] rd_rs1,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_rd0,
    output logic [4:0]  rf_ra0,
    output logic [4:0]  rf_ra1,
    output logic        rf_write_reg,
    output logic        rf_read_reg,
    input  logic [31:0] rf_rs0,
    input  logic [31:0] rf_rs1,
    output logic        busy
);
    logic [4:0]  fa [2];
    logic [31:0] fd [2];
    logic        hd;
    logic [1:0]  count;
    logic        enq, pop, blocked;

    function automatic logic hit(input logic [4:0] a, input logic [4:0] e0, input logic [4:0] e1,
                                 input logic [4:0] w, input logic v0, input logic v1, input logic vw);
        return a != 5'd0 && ((v0 && a == e0) || (v1 && a == e1) || (vw && a == w));
    endfunction

    assign wb_ready     = count != 2'(WB_DEPTH);
    assign busy         = count != 2'd0;
    assign rf_wa        = fa[hd];
    assign rf_rd0       = fd[hd];
    assign rf_ra0       = rd_ra0;
    assign rf_ra1       = rd_ra1;
    assign rd_rs0       = rf_rs0;
    assign rd_rs1       = rf_rs1;
    assign rd_req_ready = rf_read_reg;

    always_comb begin
        enq          = wb_valid && wb_ready && wb_addr != 5'd0;
        blocked      = rd_req_valid &&
                       (hit(rd_ra0, fa[hd], fa[~hd], wb_addr, busy, !wb_ready, enq) ||
                        hit(rd_ra1, fa[hd], fa[~hd], wb_addr, busy, !wb_ready, enq));
        pop          = !reset && busy && (!wb_ready || blocked || !rd_req_valid);
        rf_write_reg = pop;
        rf_read_reg  = !reset && rd_req_valid && !pop && !blocked;
    end

    always_ff @(posedge APB_PCLK) begin
        if (reset) begin
            count        <= 2'd0;
            hd           <= 1'b0;
            rd_rsp_valid <= 1'b0;
        end else begin
            count        <= count + 2'(enq) - 2'(pop);
            hd           <= hd ^ pop;
            rd_rsp_valid <= rf_read_reg;
        end
    end

    // Tail slot is head offset by occupancy; a full FIFO never enqueues.
    always_ff @(posedge APB_PCLK) begin
        if (enq) begin
            fa[hd ^ count[0]] <= wb_addr;
            fd[hd ^ count[0]] <= wb_data;
        end
    end
endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: random and directed traffic checked against an architectural register model via a response scoreboard
module tb_regfile_seq;
    logic        APB_PCLK, reset;
    logic        rd_req_valid, rd_req_ready, rd_rsp_valid;
    logic [4:0]  rd_ra0, rd_ra1, wb_addr, rf_wa, rf_ra0, rf_ra1;
    logic [31:0] rd_rs0, rd_rs1, wb_data, rf_rd0, rf_rs0, rf_rs1;
    logic        wb_valid, wb_ready, rf_write_reg, rf_read_reg, busy;

    regfile_seq dut (
        .APB_PCLK(APB_PCLK), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_ra0(rd_ra0), .rd_ra1(rd_ra1),
        .rd_rsp_valid(rd_rsp_valid), .rd_rs0(rd_rs0), .rd_rs1(rd_rs1),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_wa(rf_wa), .rf_rd0(rf_rd0), .rf_ra0(rf_ra0), .rf_ra1(rf_ra1),
        .rf_write_reg(rf_write_reg), .rf_read_reg(rf_read_reg),
        .rf_rs0(rf_rs0), .rf_rs1(rf_rs1), .busy(busy)
    );

    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [4:0] a0; logic [4:0] a1; } rd_t;
    typedef struct { logic [31:0] d0; logic [31:0] d1; int c; } rsp_t;

    int n_cmp = 0, n_err = 0, cyc = 0, rwait = 0, max_wait = 0;
    logic [31:0] mem [32];
    logic [31:0] arch [32];
    wr_t  wpend [$];
    rsp_t exp_q [$];
    rd_t  rq [$];
    wr_t  wq [$];
    logic rnd = 0, saw_full = 0, s_rdy, s_wr;

    initial begin
        APB_PCLK = 0;
        forever #5 APB_PCLK = ~APB_PCLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] lookup(input logic [4:0] a);
        logic [31:0] v = arch[a];
        foreach (wpend[i]) if (wpend[i].a == a) v = wpend[i].d;
        return a == 5'd0 ? 32'd0 : v;
    endfunction

    // Register file stand-in: synchronous write port, registered read data.
    always @(posedge APB_PCLK) begin
        if (rf_write_reg && rf_wa != 5'd0) mem[rf_wa] <= rf_rd0;
        if (rf_read_reg) begin
            rf_rs0 <= mem[rf_ra0];
            rf_rs1 <= mem[rf_ra1];
        end
    end

    // Monitor: reads see every write accepted up to and including their issue cycle.
    always @(negedge APB_PCLK) begin
        rsp_t e;
        wr_t  w;
        chk("strobe_excl", 32'(rf_write_reg & rf_read_reg), 0);
        chk("rdy_eq_read", 32'(rd_req_ready), 32'(rf_read_reg));
        if (rd_rsp_valid) begin
            if (exp_q.size() == 0) chk("spurious_rsp", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("rsp_rs0", rd_rs0, e.d0);
                chk("rsp_rs1", rd_rs1, e.d1);
                chk("rsp_latency", cyc, e.c + 1);
            end
        end else if (exp_q.size() != 0 && exp_q[0].c < cyc) begin
            chk("rsp_missing", 0, 1);
            void'(exp_q.pop_front());
        end
        if (reset) begin
            chk("rst_strobes", 32'({rf_write_reg, rf_read_reg, rd_req_ready}), 0);
            wpend.delete();
        end else begin
            chk("busy", 32'(busy), 32'(wpend.size() != 0));
            chk("wb_ready", 32'(wb_ready), 32'(wpend.size() < 2));
            if (wpend.size() == 2) saw_full = 1;
            if (rf_write_reg) begin
                if (wpend.size() == 0) chk("write_unexpected", 1, 0);
                else begin
                    w = wpend.pop_front();
                    chk("rf_wa", 32'(rf_wa), 32'(w.a));
                    chk("rf_rd0", rf_rd0, w.d);
                    arch[w.a] = w.d;
                end
            end
            if (wb_valid && wb_ready && wb_addr != 5'd0) wpend.push_back('{a: wb_addr, d: wb_data});
            if (rf_read_reg) begin
                chk("rf_ra", 32'({rf_ra0, rf_ra1}), 32'({rd_ra0, rd_ra1}));
                exp_q.push_back('{d0: lookup(rd_ra0), d1: lookup(rd_ra1), c: cyc});
            end
        end
        cyc++;
    end

    task automatic present();
        rd_t r;
        wr_t w;
        if (!rd_req_valid && rq.size() > 0 && (!rnd || $urandom_range(3) != 0)) begin
            r = rq.pop_front();
            rd_req_valid = 1; rd_ra0 = r.a0; rd_ra1 = r.a1; rwait = 0;
        end
        if (!wb_valid && wq.size() > 0 && (!rnd || $urandom_range(2) != 0)) begin
            w = wq.pop_front();
            wb_valid = 1; wb_addr = w.a; wb_data = w.d;
        end
    endtask

    task automatic step();
        logic rd_done, wb_done;
        @(negedge APB_PCLK);
        rd_done = rd_req_valid && rd_req_ready;
        wb_done = wb_valid && wb_ready;
        s_rdy = rd_req_ready;
        s_wr = rf_write_reg;
        @(posedge APB_PCLK);
        #1;
        if (rd_req_valid && !rd_done) begin
            rwait++;
            if (rwait > max_wait) max_wait = rwait;
        end
        if (rd_done) rd_req_valid = 0;
        if (wb_done) wb_valid = 0;
        present();
    endtask

    task automatic drain();
        int n = 0;
        while ((rd_req_valid || wb_valid || rq.size() != 0 || wq.size() != 0 || busy) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 1, 0);
        repeat (2) step();
    endtask

    initial begin
        reset = 1; rd_req_valid = 0; wb_valid = 0;
        rd_ra0 = 0; rd_ra1 = 0; wb_addr = 0; wb_data = 0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = i == 0 ? 32'd0 : 32'h0101_0101 * i;
            arch[i] = mem[i];
        end
        repeat (3) @(posedge APB_PCLK);
        #1 reset = 0;
        @(negedge APB_PCLK);
        chk("rst_rsp_valid", 32'(rd_rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wb_ready", 32'(wb_ready), 1);
        chk("rst_strobes_idle", 32'({rf_write_reg, rf_read_reg}), 0);
        @(posedge APB_PCLK);
        #1;

        wq.push_back('{a: 5, d: 32'hDEADBEEF}); present();
        step(); chk("wr_lat_n", 32'(s_wr), 0);
        step(); chk("wr_lat_n1", 32'(s_wr), 1);
        repeat (2) step();
        rq.push_back('{a0: 5, a1: 0}); drain();

        wq.push_back('{a: 0, d: 32'h1234}); present();
        step(); step(); chk("x0_no_write", 32'(s_wr), 0);
        rq.push_back('{a0: 0, a1: 0}); drain();

        wq.push_back('{a: 3, d: 32'h11}); rq.push_back('{a0: 9, a1: 10}); present();
        step(); chk("same_rd_first", 32'({s_rdy, s_wr}), 32'b10);
        step(); chk("same_wr_next", 32'({s_rdy, s_wr}), 32'b01);
        drain();

        wq.push_back('{a: 7, d: 32'hA5A5A5A5}); rq.push_back('{a0: 0, a1: 7}); present();
        step(); chk("raw_stall_0", 32'({s_rdy, s_wr}), 32'b00);
        step(); chk("raw_pop", 32'({s_rdy, s_wr}), 32'b01);
        step(); chk("raw_issue", 32'(s_rdy), 1);
        drain();

        saw_full = 0;
        repeat (8) rq.push_back('{a0: 1, a1: 2});
        wq.push_back('{a: 4, d: 32'h4444_0004});
        wq.push_back('{a: 5, d: 32'h5555_0005});
        wq.push_back('{a: 6, d: 32'h6666_0006});
        present(); drain();
        chk("fifo_filled", 32'(saw_full), 1);
        rq.push_back('{a0: 4, a1: 5}); rq.push_back('{a0: 6, a1: 1}); drain();

        repeat (6) rq.push_back('{a0: 1, a1: 2});
        wq.push_back('{a: 4, d: 32'hBAD0_0004});
        wq.push_back('{a: 5, d: 32'hBAD0_0005});
        present(); step(); step();
        reset = 1;
        step();
        reset = 0; rd_req_valid = 0; wb_valid = 0; rq.delete(); wq.delete();
        step(); chk("post_rst_no_write", 32'(s_wr), 0);
        rq.push_back('{a0: 4, a1: 5}); drain();

        rnd = 1;
        for (int i = 0; i < 400; i++) begin
            if (rq.size() < 2 && $urandom_range(1) == 0)
                rq.push_back('{a0: 5'($urandom_range(7)), a1: 5'($urandom_range(7))});
            if (wq.size() < 2 && $urandom_range(2) == 0)
                wq.push_back('{a: 5'($urandom_range(7)), d: $urandom});
            step();
        end
        drain();

        chk("read_wait_bound", 32'(max_wait <= 40), 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_seq.md
# regfile_seq

Request sequencer and initiator for the CPU register file. It accepts operand-read requests from decode and writeback requests from execute/memory, and buffers writebacks in a 2-entry FIFO. It drives the register file's single write port and paired read ports so that read and write strobes are never active in the same cycle. It resolves read-after-write ordering by stalling reads, with no forwarding path.

## Interface
Parameters:
- WB_DEPTH, 2, writeback FIFO depth; fixed at 2 and not required to be generic.

Ports:
- APB_PCLK  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_req_valid  in  1  operand read request.
- rd_req_ready  out  1  request issued to the register file this cycle.
- rd_ra0, rd_ra1  in  5 each  source register addresses.
- rd_rsp_valid  out  1  operands valid; registered.
- rd_rs0, rd_rs1  out  32 each  operand data; equal to rf_rs0 and rf_rs1.
- wb_valid  in  1  writeback request.
- wb_ready  out  1  writeback accepted.
- wb_addr  in  5  destination register.
- wb_data  in  32  writeback value.
- rf_wa  out  5  register file write address; equals the FIFO head address.
- rf_rd0  out  32  register file write data; equals the FIFO head data.
- rf_ra0, rf_ra1  out  5 each  register file read addresses; equal rd_ra0 and rd_ra1.
- rf_write_reg  out  1  register file write strobe.
- rf_read_reg  out  1  register file read strobe.
- rf_rs0, rf_rs1  in  32 each  register file read data; registered inside the register file.
- busy  out  1  FIFO non-empty.

## Operation
- Writeback acceptance:
  - wb_ready = (count < 2).
  - A writeback with wb_addr == 0 is accepted and discarded; it is never enqueued.
  - Enqueue and pop may occur in the same cycle; count updates by the net amount.
- Hazard:
  - A read is blocked when a nonzero rd_ra0 or rd_ra1 matches either valid FIFO entry.
  - It is also blocked when a nonzero rd_ra0 or rd_ra1 matches a nonzero write accepted in the same cycle.
  - Ordering is write-before-read.
- Issue arbitration, one action per cycle:
  1. If count == 2, or a read is blocked, or no read is requested while count > 0: pop the head and pulse rf_write_reg.
  2. Otherwise, if rd_req_valid: pulse rf_read_reg and assert rd_req_ready.
  3. Otherwise: idle.
- Invariants:
  - rf_write_reg and rf_read_reg are never both 1.
  - rf_write_reg is never asserted with rf_wa == 0.
- rd_req_ready is combinational and equals rf_read_reg.
- busy = (count != 0).

## Timing
- Reset values:
  - count = 0; FIFO empty.
  - rd_rsp_valid = 0, busy = 0.
  - rf_write_reg = 0, rf_read_reg = 0, wb_ready = 1.
  - rd_req_ready = 0 while reset is high.
- Read latency:
  - rf_read_reg in cycle N gives rd_rsp_valid = 1 in cycle N+1 with rd_rs0/rd_rs1 valid.
  - rd_rsp_valid is a single-cycle pulse per issued read.
- Write latency:
  - Into an empty FIFO with no competing read, a write accepted in cycle N drives rf_write_reg in cycle N+1.
  - A read issued in cycle N+2 or later observes the written value.
- Back-to-back reads sustain one per cycle while no writes are pending.
- Full FIFO:
  - Write has priority over reads, so reads cannot starve writeback.
  - A read is delayed by at most 2 cycles when no hazard exists.
- Reset mid-operation:
  - Pending writes are discarded; no strobe is driven while reset is high.
  - A read issued in the cycle before reset still returns rd_rsp_valid = 0 if reset is high at that edge.

## Test plan
- Write x5 = 0xDEADBEEF, idle, then read ra0 = 5, ra1 = 0: rf_write_reg pulses once; rd_rsp_valid is 1 one cycle after rd_req_ready, with rd_rs0 = 0xDEADBEEF and rd_rs1 = 0.
- wb_valid with wb_addr = 0 and data 0x1234: wb_ready = 1, no rf_write_reg pulse, busy stays 0; a later read of x0 returns 0.
- Same cycle, empty FIFO, write x3 = 0x11 and read ra0 = 9, ra1 = 10:
  - The read issues first.
  - The write pops the next cycle.
  - The strobes are never both high in any cycle.
- Write x7 = 0xA5A5A5A5 and read ra1 = 7 in the same cycle: rd_req_ready stays 0 until the write pops; the response then has rd_rs1 = 0xA5A5A5A5.
- Continuous reads of x1/x2 plus three back-to-back writes to x4, x5, x6:
  - wb_ready drops at count = 2.
  - Writes issue at full priority.
  - All three values read back correctly.
- Two writes pending, then reset held for 1 cycle:
  - No rf_write_reg afterwards; busy = 0 and wb_ready = 1.
  - A read of x4 returns its pre-write value.
